// File: rtl/task_ctrl_pkg.sv
// Shared register map, bit positions and AXI response codes for the task-control register bank.
package task_ctrl_pkg;

  localparam logic [4:0] OFF_ID        = 5'h00;
  localparam logic [4:0] OFF_ENABLED   = 5'h04;
  localparam logic [4:0] OFF_CONTROL   = 5'h08;
  localparam logic [4:0] OFF_STATUS    = 5'h0C;
  localparam logic [4:0] OFF_CUR_TASK  = 5'h10;
  localparam logic [4:0] OFF_SCRATCH   = 5'h14;
  localparam logic [4:0] OFF_DONE_CNT  = 5'h18;

  localparam int CTRL_START_BIT    = 0;
  localparam int CTRL_CLR_DONE_BIT = 1;
  localparam int STAT_DONE_BIT     = 0;
  localparam int STAT_RUNNING_BIT  = 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [31:0] ID_VALUE_DEFAULT = 32'h7A5C_0001;

endpackage

// File: rtl/task_ctrl_axil_regs.sv
// AXI4-Lite register bank for the task-test control path: task mask, start pulse,
// completion status, current task number and done count.
module task_ctrl_axil_regs
  import task_ctrl_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = ID_VALUE_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [DATA_WIDTH-1:0]   enabled_tasks,
  output logic                    start_tests,
  input  logic [DATA_WIDTH-1:0]   current_task_number,
  input  logic                    tasks_done
);

  logic                    aw_full, w_full, b_valid_q, r_valid_q, start_q;
  logic [4:0]              aw_off;
  logic                    aw_mapped;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [1:0]              b_resp_q, r_resp_q;
  logic [DATA_WIDTH-1:0]   r_data_q, enabled_q, scratch_q, done_cnt_q;
  logic                    done_q, running_q, td_q;

  logic                    aw_hs, w_hs, ar_hs, commit, td_rise;
  logic                    wr_enabled, wr_scratch, wr_control, start_hit, clr_hit;
  logic [1:0]              wr_resp, rd_resp;
  logic [4:0]              rd_off;
  logic                    rd_mapped;
  logic [DATA_WIDTH-1:0]   rd_val, status_word;
  logic                    unused_addr_lsbs;

  function automatic logic addr_mapped(input logic [ADDR_WIDTH-3:0] wa);
    return (wa[ADDR_WIDTH-3:3] == '0) && (wa[2:0] != 3'd7);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_strb(input logic [DATA_WIDTH-1:0]   old_v,
                                                       input logic [DATA_WIDTH-1:0]   new_v,
                                                       input logic [DATA_WIDTH/8-1:0] strb);
    logic [DATA_WIDTH-1:0] res;
    res = old_v;
    for (int i = 0; i < DATA_WIDTH/8; i++)
      if (strb[i]) res[i*8 +: 8] = new_v[i*8 +: 8];
    return res;
  endfunction

  assign unused_addr_lsbs = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  assign s_axi_awready = !aw_full && !b_valid_q && !i_rst;
  assign s_axi_wready  = !w_full  && !b_valid_q && !i_rst;
  assign s_axi_arready = !r_valid_q && !i_rst;

  assign aw_hs   = s_axi_awvalid && s_axi_awready;
  assign w_hs    = s_axi_wvalid  && s_axi_wready;
  assign ar_hs   = s_axi_arvalid && s_axi_arready;
  assign commit  = aw_full && w_full && !b_valid_q;
  assign td_rise = tasks_done && !td_q;

  always_comb begin
    wr_resp    = RESP_DECERR;
    wr_enabled = 1'b0;
    wr_scratch = 1'b0;
    wr_control = 1'b0;
    if (aw_mapped) begin
      wr_resp = RESP_SLVERR;
      case (aw_off)
        OFF_ENABLED: begin wr_resp = RESP_OKAY; wr_enabled = 1'b1; end
        OFF_SCRATCH: begin wr_resp = RESP_OKAY; wr_scratch = 1'b1; end
        OFF_CONTROL: begin wr_resp = RESP_OKAY; wr_control = 1'b1; end
        default:     wr_resp = RESP_SLVERR;
      endcase
    end
  end

  // CONTROL only looks at the low byte lane
  assign start_hit = commit && wr_control && w_strb[0] && w_data[CTRL_START_BIT];
  assign clr_hit   = commit && wr_control && w_strb[0] && w_data[CTRL_CLR_DONE_BIT];

  assign rd_off    = {s_axi_araddr[4:2], 2'b00};
  assign rd_mapped = addr_mapped(s_axi_araddr[ADDR_WIDTH-1:2]);

  always_comb begin
    status_word                   = '0;
    status_word[STAT_DONE_BIT]    = done_q;
    status_word[STAT_RUNNING_BIT] = running_q;
    rd_val  = '0;
    rd_resp = RESP_DECERR;
    if (rd_mapped) begin
      rd_resp = RESP_OKAY;
      case (rd_off)
        OFF_ID:       rd_val = ID_VALUE;
        OFF_ENABLED:  rd_val = enabled_q;
        OFF_STATUS:   rd_val = status_word;
        OFF_CUR_TASK: rd_val = current_task_number;
        OFF_SCRATCH:  rd_val = scratch_q;
        OFF_DONE_CNT: rd_val = done_cnt_q;
        default:      rd_val = '0;
      endcase
    end
  end

  // p0: holding-register payloads, qualified by the full flags below
  always_ff @(posedge i_clk) begin
    if (aw_hs) begin
      aw_off    <= {s_axi_awaddr[4:2], 2'b00};
      aw_mapped <= addr_mapped(s_axi_awaddr[ADDR_WIDTH-1:2]);
    end
    if (w_hs) begin
      w_data <= s_axi_wdata;
      w_strb <= s_axi_wstrb;
    end
  end

  // p1: commit, responses, status tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      aw_full    <= 1'b0;
      w_full     <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= 2'b00;
      r_valid_q  <= 1'b0;
      r_resp_q   <= 2'b00;
      r_data_q   <= '0;
      start_q    <= 1'b0;
      enabled_q  <= '0;
      scratch_q  <= '0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
      done_cnt_q <= '0;
      td_q       <= 1'b0;
    end else begin
      if (aw_hs) aw_full <= 1'b1;
      if (w_hs)  w_full  <= 1'b1;
      start_q <= start_hit;
      if (commit) begin
        aw_full   <= 1'b0;
        w_full    <= 1'b0;
        b_valid_q <= 1'b1;
        b_resp_q  <= wr_resp;
        if (wr_enabled) enabled_q <= merge_strb(enabled_q, w_data, w_strb);
        if (wr_scratch) scratch_q <= merge_strb(scratch_q, w_data, w_strb);
      end else if (b_valid_q && s_axi_bready) begin
        b_valid_q <= 1'b0;
      end

      td_q   <= tasks_done;
      done_q <= (done_q && !clr_hit) || td_rise;
      if (start_hit)    running_q <= 1'b1;
      else if (td_rise) running_q <= 1'b0;
      if (td_rise) done_cnt_q <= done_cnt_q + DATA_WIDTH'(1);

      if (ar_hs) begin
        r_valid_q <= 1'b1;
        r_data_q  <= rd_val;
        r_resp_q  <= rd_resp;
      end else if (r_valid_q && s_axi_rready) begin
        r_valid_q <= 1'b0;
      end
    end
  end

  assign s_axi_bvalid  = b_valid_q;
  assign s_axi_bresp   = b_resp_q;
  assign s_axi_rvalid  = r_valid_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = r_resp_q;
  assign enabled_tasks = enabled_q;
  assign start_tests   = start_q;

endmodule

// File: tb/tb_task_ctrl_axil_regs.sv
// Directed self-checking bench for task_ctrl_axil_regs.
module tb_task_ctrl_axil_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] awaddr, wdata, araddr, rdata, enabled_tasks, cur_task;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, start_tests, tasks_done;
  logic [1:0]  bresp, rresp;

  int total = 0;
  int bad   = 0;

  task_ctrl_axil_regs dut (
    .i_clk(clk), .i_rst(rst),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .enabled_tasks(enabled_tasks), .start_tests(start_tests),
    .current_task_number(cur_task), .tasks_done(tasks_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    bit aw_done = 0, w_done = 0, got = 0;
    bit a_ok, d_ok;
    resp = 2'b01;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 1;
    for (int i = 0; i < 20 && !(aw_done && w_done); i++) begin
      a_ok = awvalid && awready;
      d_ok = wvalid && wready;
      step();
      if (a_ok) begin awvalid = 0; aw_done = 1; end
      if (d_ok) begin wvalid = 0; w_done = 1; end
    end
    for (int i = 0; i < 20 && !got; i++) begin
      if (bvalid) begin resp = bresp; got = 1; end
      step();
    end
    awvalid = 0; wvalid = 0; bready = 0;
    if (!(aw_done && w_done && got)) check("wr_timeout", 32'd0, 32'd1);
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    bit acc = 0, got = 0, ok;
    data = 32'hFFFF_FFFF; resp = 2'b01;
    araddr = addr; arvalid = 1; rready = 1;
    for (int i = 0; i < 20 && !acc; i++) begin
      ok = arready;
      step();
      if (ok) acc = 1;
    end
    arvalid = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (rvalid) begin data = rdata; resp = rresp; got = 1; end
      step();
    end
    rready = 0;
    if (!(acc && got)) check("rd_timeout", 32'd0, 32'd1);
  endtask

  // present AW and W together with BREADY low; both get captured on the next edge
  task automatic aw_w_capture(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1; wvalid = 1; bready = 0;
    check("aw_w_ready", {30'd0, awready, wready}, 32'd3);
    step();
    awvalid = 0; wvalid = 0;
  endtask

  logic [31:0] d;
  logic [1:0]  r;

  initial begin
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arvalid = 0; rready = 0; tasks_done = 0; cur_task = 32'h1234_5678;
    step(); step(); step();
    check("rst_readies", {29'd0, awready, wready, arready}, 32'd0);
    check("rst_valids", {29'd0, bvalid, rvalid, start_tests}, 32'd0);
    check("rst_enabled", enabled_tasks, 32'd0);
    rst = 0;
    step();
    check("idle_readies", {29'd0, awready, wready, arready}, 32'd7);

    axi_read(32'h00, d, r);
    check("id_data", d, 32'h7A5C_0001);
    check("id_resp", {30'd0, r}, 32'd0);
    axi_read(32'h04, d, r);
    check("enabled_reset", d, 32'd0);

    // W leads AW by three cycles
    wdata = 32'hDEAD_BEEF; wstrb = 4'b0101; wvalid = 1;
    step();
    wvalid = 0;
    check("w_held_wready", {31'd0, wready}, 32'd0);
    step(); step();
    awaddr = 32'h04; awvalid = 1;
    check("aw_ready_late", {31'd0, awready}, 32'd1);
    step();
    awvalid = 0;
    step();
    check("strb_bvalid", {31'd0, bvalid}, 32'd1);
    check("strb_bresp", {30'd0, bresp}, 32'd0);
    bready = 1;
    step();
    bready = 0;
    check("enabled_strb", enabled_tasks, 32'h00AD_00EF);

    // START: pulse coincides with BVALID
    aw_w_capture(32'h08, 32'h1, 4'hF);
    check("start_pre", {31'd0, start_tests}, 32'd0);
    step();
    check("start_pulse", {30'd0, start_tests, bvalid}, 32'd3);
    check("start_bresp", {30'd0, bresp}, 32'd0);
    bready = 1;
    step();
    bready = 0;
    check("start_gone", {30'd0, start_tests, bvalid}, 32'd0);
    axi_read(32'h0C, d, r);
    check("status_running", d, 32'h2);

    // CLR_DONE lands on the first tasks_done rising edge; set wins
    aw_w_capture(32'h08, 32'h2, 4'h1);
    tasks_done = 1;
    step();
    bready = 1;
    step();
    bready = 0; tasks_done = 0;
    step();
    tasks_done = 1;
    step();
    tasks_done = 0;
    step();
    axi_read(32'h0C, d, r);
    check("status_done", d, 32'h1);
    axi_read(32'h18, d, r);
    check("done_count2", d, 32'd2);

    // START on the same edge as a tasks_done rise keeps RUNNING
    aw_w_capture(32'h08, 32'h1, 4'h1);
    tasks_done = 1;
    step();
    bready = 1;
    step();
    bready = 0; tasks_done = 0;
    axi_read(32'h0C, d, r);
    check("status_start_rise", d, 32'h3);
    axi_read(32'h18, d, r);
    check("done_count3", d, 32'd3);

    axi_read(32'h10, d, r);
    check("cur_task", d, 32'h1234_5678);
    axi_read(32'h08, d, r);
    check("control_reads0", d, 32'd0);

    // read-only write with BREADY held off
    aw_w_capture(32'h0C, 32'hFFFF_FFFF, 4'hF);
    step();
    check("ro_bvalid", {31'd0, bvalid}, 32'd1);
    check("ro_bresp", {30'd0, bresp}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("b_stall_ready", {30'd0, awready, wready}, 32'd0);
      step();
    end
    bready = 1;
    step();
    bready = 0;
    check("b_done_ready", {29'd0, bvalid, awready, wready}, 32'd3);
    axi_read(32'h0C, d, r);
    check("status_unchanged", d, 32'h3);

    axi_read(32'h40, d, r);
    check("unmapped_rd_data", d, 32'd0);
    check("unmapped_rd_resp", {30'd0, r}, 32'd3);
    axi_read(32'h1C, d, r);
    check("rd_1c_resp", {30'd0, r}, 32'd3);
    axi_write(32'h1C, 32'h5, 4'hF, r);
    check("wr_1c_resp", {30'd0, r}, 32'd3);

    axi_write(32'h14, 32'h1122_3344, 4'hF, r);
    check("scratch_wr_resp", {30'd0, r}, 32'd0);
    axi_write(32'h14, 32'hAABB_CCDD, 4'b1000, r);
    axi_read(32'h14, d, r);
    check("scratch_merge", d, 32'hAA22_3344);

    // reset while a read response is waiting
    araddr = 32'h00; arvalid = 1; rready = 0;
    step();
    arvalid = 0;
    check("r_pending", {31'd0, rvalid}, 32'd1);
    rst = 1;
    step();
    check("r_dropped", {30'd0, rvalid, arready}, 32'd0);
    rst = 0;
    step();
    check("rst_enabled2", enabled_tasks, 32'd0);
    axi_read(32'h14, d, r);
    check("scratch_after_rst", d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
